// File: rtl/fft_sequencer.sv
// -----------------------------------------------------------------------------
// fft_sequencer
//
// Control and address sequencer for an in-place radix-2 decimation-in-frequency
// FFT built around one shared combinational butterfly
// (out1 = x + y, out2 = (x - y) * W). After start it walks all N_LOG2 stages,
// issuing N/2 butterflies per stage: one read-address pair plus a twiddle index
// per cycle. The matching write-back addresses come out PIPE cycles later. Each
// stage ends with a PIPE-cycle drain, so every write of stage s has landed
// before stage s+1 reads. Results are left in bit-reversed order.
//
// Optional feature macro: FFT_HOLD_EN
//   When it is defined the block gains a hold_i input that stalls issue while
//   the sequencer is in RUN. When it is undefined the block behaves as if
//   hold_i were tied low.
//
// Parameters
//   N_LOG2 : log2 of the transform size N (2..15)
//   PIPE   : cycles from a read issue to its write-back (>= 1)
//
// Ports
//   clk_i        clock; all logic runs on the rising edge
//   rst_i        synchronous, active-high reset
//   start_i      begin a transform; sampled only in IDLE
//   hold_i       (FFT_HOLD_EN only) stall issue while in RUN
//   busy_o       high while issuing or draining
//   done_o       one-cycle pulse when the transform completes
//   stage_o      current stage index while busy, otherwise 0
//   rd_en_o      read strobe for RAM ports A/B and the twiddle ROM
//   rd_addr_a_o  upper-leg (x) read address
//   rd_addr_b_o  lower-leg (y) read address
//   tw_addr_o    twiddle ROM index k, where W = exp(-j*2*pi*k/N)
//   wr_en_o      write-back strobe (out1 -> addr_a, out2 -> addr_b)
//   wr_addr_a_o  write address for out1
//   wr_addr_b_o  write address for out2
// -----------------------------------------------------------------------------
module fft_sequencer #(
  parameter int N_LOG2 = 6,
  parameter int PIPE   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
`ifdef FFT_HOLD_EN
  input  logic              hold_i,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic [3:0]        stage_o,
  output logic              rd_en_o,
  output logic [N_LOG2-1:0] rd_addr_a_o,
  output logic [N_LOG2-1:0] rd_addr_b_o,
  output logic [N_LOG2-2:0] tw_addr_o,
  output logic              wr_en_o,
  output logic [N_LOG2-1:0] wr_addr_a_o,
  output logic [N_LOG2-1:0] wr_addr_b_o
);

  localparam int JW = N_LOG2 - 1;                    // butterfly index width
  localparam int CW = (PIPE > 1) ? $clog2(PIPE) : 1; // drain counter width

  localparam logic [N_LOG2-1:0] HALF_L = N_LOG2'(1) << (N_LOG2 - 1);
  localparam logic [N_LOG2-1:0] ONE_L  = N_LOG2'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  // One write-back slot: the addresses travel with their own valid bit.
  typedef struct packed {
    logic              valid;
    logic [N_LOG2-1:0] addr_a;
    logic [N_LOG2-1:0] addr_b;
  } wb_t;

  // ---------------------------------------------------------------------------
  // Optional hold input
  // ---------------------------------------------------------------------------
  logic hold;
`ifdef FFT_HOLD_EN
  assign hold = hold_i;
`else
  assign hold = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  state_e         state_q, state_d;
  logic [3:0]     s_q, s_d;     // stage index
  logic [JW-1:0]  j_q, j_d;     // butterfly index within the stage
  logic [CW-1:0]  cnt_q, cnt_d; // drain cycle counter

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      j_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      j_q     <= j_d;
      cnt_q   <= cnt_d;
    end
  end

  logic last_j;
  logic last_stage;
  logic drain_end;

  assign last_j     = (j_q == '1);                  // j == N/2 - 1
  assign last_stage = (s_q == 4'(N_LOG2 - 1));
  assign drain_end  = (cnt_q == CW'(PIPE - 1));

  // Next-state logic.
  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          s_d     = '0;
          j_d     = '0;
        end
      end
      S_RUN: begin
        if (!hold) begin
          j_d = j_q + JW'(1);
          if (last_j) begin
            state_d = S_DRAIN;
            j_d     = '0;
            cnt_d   = '0;
          end
        end
      end
      S_DRAIN: begin
        if (drain_end) begin
          cnt_d = '0;
          if (last_stage) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            s_d     = s_q + 4'd1;
            j_d     = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        s_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Address generation for butterfly j of stage s.
  // span = N >> (s+1). The group bits of j sit above the pos bits. Shifting
  // the group bits up by one opens a zero at the span position. That gives
  // grp*2*span + pos for the upper leg, and setting the span bit gives the
  // lower leg.
  // ---------------------------------------------------------------------------
  logic [N_LOG2-1:0] span;
  logic [N_LOG2-1:0] mask;
  logic [N_LOG2-1:0] j_ext;
  logic [N_LOG2-1:0] pos;
  logic [N_LOG2-1:0] addr_a;
  logic [N_LOG2-1:0] addr_b;
  logic [JW-1:0]     tw;

  always_comb begin
    span   = HALF_L >> s_q;
    mask   = span - ONE_L;
    j_ext  = {1'b0, j_q};
    pos    = j_ext & mask;
    addr_a = ((j_ext & ~mask) << 1) | pos;
    addr_b = addr_a | span;
    // pos < span <= N/2, so pos always fits in JW bits. The product pos << s
    // is below N/2, so the shifted value also fits in JW bits.
    tw     = pos[JW-1:0] << s_q;
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  logic              issue;
  logic              busy_d, done_d, rd_en_d;
  logic [3:0]        stage_d;
  logic [N_LOG2-1:0] rd_addr_a_d, rd_addr_b_d;
  logic [JW-1:0]     tw_addr_d;

  assign issue = (state_q == S_RUN) && !hold;

  always_comb begin
    busy_d      = (state_q == S_RUN) || (state_q == S_DRAIN);
    done_d      = (state_q == S_DONE);
    stage_d     = busy_d ? s_q : 4'd0;
    rd_en_d     = issue;
    rd_addr_a_d = issue ? addr_a : '0;
    rd_addr_b_d = issue ? addr_b : '0;
    tw_addr_d   = issue ? tw     : '0;
  end

  // ---------------------------------------------------------------------------
  // Registered outputs and write-back pipeline
  // ---------------------------------------------------------------------------
  logic              busy_q, done_q, rd_en_q;
  logic [3:0]        stage_q;
  logic [N_LOG2-1:0] rd_addr_a_q, rd_addr_b_q;
  logic [JW-1:0]     tw_addr_q;
  wb_t               pipe_q [PIPE];

  // NOTE: the write-back pipeline is cleared in full on reset, not just its
  // valid bits. A reset mid-transform must not let a stale write finish, and
  // zeroing the addresses keeps them at 0 while the strobe is low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stage_q     <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_addr_q   <= '0;
      for (int i = 0; i < PIPE; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      stage_q     <= stage_d;
      rd_en_q     <= rd_en_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      tw_addr_q   <= tw_addr_d;
      // Slot 0 captures the registered read issue, so slot PIPE-1 presents
      // it exactly PIPE cycles after rd_en_o showed it.
      pipe_q[0]   <= '{valid: rd_en_q, addr_a: rd_addr_a_q, addr_b: rd_addr_b_q};
      for (int i = 1; i < PIPE; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign stage_o     = stage_q;
  assign rd_en_o     = rd_en_q;
  assign rd_addr_a_o = rd_addr_a_q;
  assign rd_addr_b_o = rd_addr_b_q;
  assign tw_addr_o   = tw_addr_q;
  assign wr_en_o     = pipe_q[PIPE-1].valid;
  assign wr_addr_a_o = pipe_q[PIPE-1].addr_a;
  assign wr_addr_b_o = pipe_q[PIPE-1].addr_b;

endmodule

// File: tb/tb_fft_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fft_sequencer
//
// Directed bench for fft_sequencer. An N=8 instance is checked cycle by cycle
// against hand-written issue tables. It also covers a held start and a reset
// in mid-transform. An N=64 instance drives a behavioural sample RAM, a Q1.15
// twiddle ROM and a butterfly, and transforms a unit impulse.
// -----------------------------------------------------------------------------
module tb_fft_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start3, start6, hold3, load6;

  // N = 8 instance
  logic       busy3, done3, rd_en3, wr_en3;
  logic [3:0] stage3;
  logic [2:0] ra3, rb3, wa3, wb3;
  logic [1:0] tw3;

  // N = 64 instance
  logic       busy6, done6, rd_en6, wr_en6;
  logic [3:0] stage6;
  logic [5:0] ra6, rb6, wa6, wb6;
  logic [4:0] tw6;

  fft_sequencer #(.N_LOG2(3), .PIPE(2)) dut3 (
    .clk_i(clk), .rst_i(rst), .start_i(start3),
`ifdef FFT_HOLD_EN
    .hold_i(hold3),
`endif
    .busy_o(busy3), .done_o(done3), .stage_o(stage3),
    .rd_en_o(rd_en3), .rd_addr_a_o(ra3), .rd_addr_b_o(rb3), .tw_addr_o(tw3),
    .wr_en_o(wr_en3), .wr_addr_a_o(wa3), .wr_addr_b_o(wb3)
  );

  fft_sequencer #(.N_LOG2(6), .PIPE(2)) dut6 (
    .clk_i(clk), .rst_i(rst), .start_i(start6),
`ifdef FFT_HOLD_EN
    .hold_i(1'b0),
`endif
    .busy_o(busy6), .done_o(done6), .stage_o(stage6),
    .rd_en_o(rd_en6), .rd_addr_a_o(ra6), .rd_addr_b_o(rb6), .tw_addr_o(tw6),
    .wr_en_o(wr_en6), .wr_addr_a_o(wa6), .wr_addr_b_o(wb6)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Hand-computed N=8 issue table (stage-major).
  // ---------------------------------------------------------------------------
  int ea[12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
  int eb[12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
  int et[12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};
  int issue_cyc[12];
  int done_cyc;

  // {rd_en, addr_a, addr_b, tw} expected in cycle c
  function automatic logic [8:0] exp_rd(input int c);
    for (int k = 0; k < 12; k++)
      if (issue_cyc[k] == c) return {1'b1, 3'(ea[k]), 3'(eb[k]), 2'(et[k])};
    return '0;
  endfunction

  // {wr_en, addr_a, addr_b} expected in cycle c: the issue from 2 cycles before
  function automatic logic [6:0] exp_wr(input int c);
    logic [8:0] r;
    r = exp_rd(c - 2);
    return r[8:2];
  endfunction

  // {busy, done, stage} expected in cycle c
  function automatic logic [5:0] exp_ctl(input int c);
    logic       b;
    logic [3:0] s;
    b = (c >= 1) && (c < done_cyc);
    s = !b ? 4'd0 : (c >= issue_cyc[8]) ? 4'd2 : (c >= issue_cyc[4]) ? 4'd1 : 4'd0;
    return {b, (c == done_cyc), s};
  endfunction

  // ---------------------------------------------------------------------------
  // N=64 behavioural datapath: sample RAM (1-cycle read), Q1.15 twiddle ROM,
  // butterfly with an output register. Issue -> write-back is 2 cycles.
  // ---------------------------------------------------------------------------
  int     re6 [64];
  int     im6 [64];
  int     rom_re [32];
  int     rom_im [32];
  int     xr, xi, yr, yi, wr_c, wi_c;
  int     o1r, o1i, o2r, o2i;
  longint dr, di;

  initial begin
    for (int k = 0; k < 32; k++) begin
      rom_re[k] = int'($floor(32767.0 * $cos(2.0 * 3.14159265358979 * k / 64.0) + 0.5));
      rom_im[k] = int'($floor(-32767.0 * $sin(2.0 * 3.14159265358979 * k / 64.0) + 0.5));
    end
  end

  always @(posedge clk) begin
    if (load6) begin
      for (int i = 0; i < 64; i++) begin
        re6[i] <= (i == 0) ? 32'h1000 : 0;
        im6[i] <= 0;
      end
    end else if (wr_en6) begin
      re6[wa6] <= o1r;
      im6[wa6] <= o1i;
      re6[wb6] <= o2r;
      im6[wb6] <= o2i;
    end
    if (rd_en6) begin
      xr   <= re6[ra6];
      xi   <= im6[ra6];
      yr   <= re6[rb6];
      yi   <= im6[rb6];
      wr_c <= rom_re[tw6];
      wi_c <= rom_im[tw6];
    end
    dr = longint'(xr - yr);
    di = longint'(xi - yi);
    o1r <= xr + yr;
    o1i <= xi + yi;
    o2r <= int'((dr * wr_c - di * wi_c + 16384) >>> 15);
    o2i <= int'((dr * wi_c + di * wr_c + 16384) >>> 15);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int dones, issues, writes, dc;
    logic rd20;

    rst = 1'b1; start3 = 1'b0; start6 = 1'b0; hold3 = 1'b0; load6 = 1'b0;

`ifdef FFT_HOLD_EN
    issue_cyc = '{1, 5, 6, 7, 10, 11, 12, 13, 16, 17, 18, 19};
    done_cyc  = 22;
`else
    issue_cyc = '{1, 2, 3, 4, 7, 8, 9, 10, 13, 14, 15, 16};
    done_cyc  = 19;
`endif

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_n8", {busy3, done3, stage3, rd_en3, ra3, rb3, tw3, wr_en3, wa3, wb3}, '0);
    check("reset_n64", {busy6, done6, stage6, rd_en6, ra6, rb6, tw6, wr_en6, wa6, wb6}, '0);

    // --- N=8 exact issue / write-back / control sequence ---------------------
    start3 = 1'b1;
    tick();                          // edge 0 samples start
    start3 = 1'b0;
    check("c0_rd", {rd_en3, ra3, rb3, tw3}, exp_rd(0));
    check("c0_ctl", {busy3, done3, stage3}, exp_ctl(0));
    for (int c = 1; c <= done_cyc + 2; c++) begin
      hold3 = (c >= 2) && (c <= 4);
      tick();
      check($sformatf("c%0d_rd", c), {rd_en3, ra3, rb3, tw3}, exp_rd(c));
      check($sformatf("c%0d_wr", c), {wr_en3, wa3, wb3}, exp_wr(c));
      check($sformatf("c%0d_ctl", c), {busy3, done3, stage3}, exp_ctl(c));
    end
    hold3 = 1'b0;

    // --- start held high: one transform, restart only after done ------------
    start3 = 1'b1;
    tick();                          // edge 0
    dones = 0; issues = 0; rd20 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      dones  += int'(done3);
      issues += int'(rd_en3);
      if (c == 19) check("held_done19", {busy3, done3}, 2'b01);
      if (c == 20) rd20 = rd_en3;
    end
    check("held_dones", dones, 1);
    check("held_issues", issues, 12);
    check("held_rd_c20", rd20, 1'b0);
    tick();                          // cycle 21
    check("held_restart_c21", {rd_en3, ra3, rb3}, {1'b1, 3'd0, 3'd4});
    start3 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // --- reset mid-transform -------------------------------------------------
    start3 = 1'b1;
    tick();                          // edge 0
    start3 = 1'b0;
    for (int c = 1; c <= 10; c++) tick();
    check("pre_rst_c10", {busy3, stage3, rd_en3}, {1'b1, 4'd1, 1'b1});
    rst = 1'b1;
    tick();                          // cycle 11
    rst = 1'b0;
    check("rst_mid", {busy3, done3, rd_en3, wr_en3, stage3}, '0);
    writes = 0; issues = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      writes += int'(wr_en3);
      issues += int'(rd_en3);
    end
    check("rst_no_stale_wr", writes, 0);
    check("rst_no_rd", issues, 0);

    // --- N=64 full datapath, unit impulse ------------------------------------
    load6 = 1'b1;
    tick();
    load6  = 1'b0;
    start6 = 1'b1;
    tick();                          // edge 0
    start6 = 1'b0;
    dc = -1;
    for (int c = 1; c <= 400; c++) begin
      tick();
      if (done6) begin
        dc = c;
        break;
      end
    end
    check("n64_done_cycle", dc, 6 * (32 + 2) + 1);
    repeat (3) tick();
    for (int i = 0; i < 64; i++)
      check($sformatf("n64_bin%0d", i), {re6[i], im6[i]}, {32'h1000, 32'h0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_sequencer.md
# fft_sequencer

In-place radix-2 decimation-in-frequency FFT sequencer that drives a single shared combinational butterfly. The butterfly computes out1 = x + y and out2 = (x − y)·W. On `start`, the block walks all log2(N) stages and N/2 butterflies per stage. Each cycle it issues read addresses for a sample-RAM pair plus a twiddle-ROM index, then issues the matching write-back after a fixed pipeline delay. It sits between the host load/unload logic and the sample RAM, twiddle ROM and butterfly; results are left in RAM in bit-reversed order.

## Interface
- N_LOG2, 6, log2 of transform size N; legal range 2..15
- PIPE, 2, cycles from a read issue to its write-back (RAM read latency plus butterfly output register); ≥1

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin transform; sampled only in IDLE
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when the transform completes
- stage  out  4  current stage index s, 0..N_LOG2−1
- rd_en  out  1  read issue strobe for RAM ports A/B and twiddle ROM
- rd_addr_a  out  N_LOG2  upper-leg (x) address
- rd_addr_b  out  N_LOG2  lower-leg (y) address
- tw_addr  out  N_LOG2−1  twiddle ROM index k (W = e^(−j2πk/N), Q1.15)
- wr_en  out  1  write-back strobe for out1→addr_a, out2→addr_b
- wr_addr_a  out  N_LOG2  write address for out1
- wr_addr_b  out  N_LOG2  write address for out2

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE + start=1 → RUN with s=0, j=0.
- RUN: each cycle issues butterfly j of stage s (rd_en=1), then j←j+1. The cycle that issues j = N/2−1 → DRAIN.
- DRAIN: counts PIPE cycles with rd_en=0.
  - At the end of the count with s < N_LOG2−1: s←s+1, j←0, → RUN.
  - At the end of the count with s = N_LOG2−1: → DONE.
- DONE: done=1 for exactly one cycle, → IDLE.
- Address generation for L = N_LOG2:
  - span = N >> (s+1)
  - grp = j >> (L−1−s)
  - pos = j & (span−1)
  - rd_addr_a = grp·2·span + pos
  - rd_addr_b = rd_addr_a + span
  - tw_addr = pos << s, truncated to N_LOG2−1 bits
- Write-back is a PIPE-deep shift pipeline carrying {valid, addr_a, addr_b}.
  - wr_en, wr_addr_a and wr_addr_b equal rd_en, rd_addr_a and rd_addr_b delayed by exactly PIPE cycles.
- DRAIN guarantees every write of stage s has committed before stage s+1 issues its first read. No read-after-write hazard checking is done otherwise.
- start while not in IDLE is ignored. start and rst in the same cycle: rst wins.
- rst mid-transform: next state IDLE, j=s=0, all pipeline valid bits cleared. wr_en is 0 from the cycle after rst, and no stale write completes. RAM contents are undefined to the host.
- Reset values: busy=0, done=0, stage=0, rd_en=0, wr_en=0, all addresses 0.
- Address and index outputs are 0 whenever their strobe is 0.

## Timing
- start sampled high in IDLE at cycle 0 → first rd_en at cycle 1.
- Each stage: N/2 issue cycles + PIPE drain cycles.
- Last write of the transform at cycle N_LOG2·(N/2+PIPE).
- done pulses at cycle N_LOG2·(N/2+PIPE)+1, with busy=0 in that cycle.
- The earliest accepted re-start is the cycle after done.
- Outputs are registered; the RAM must make a write visible to a read issued the following cycle.

## Configuration
- FFT_HOLD_EN defined:
  - Adds input port `hold` (1 bit).
  - In RUN with hold=1: no issue (rd_en=0), j unchanged, and the state stays in RUN.
  - In-flight pipeline entries keep advancing, so writes still complete PIPE cycles after their issue.
  - hold has no effect in IDLE, DRAIN or DONE.
- FFT_HOLD_EN undefined: no `hold` port; behaviour is identical to hold tied 0.

## Test plan
- N_LOG2=3, PIPE=2, start pulse → exact issue sequences:
  - stage 0 pairs (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3
  - stage 1 pairs (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2
  - stage 2 pairs (0,1),(2,3),(4,5),(6,7), tw 0,0,0,0
  - done at cycle 19
- Same config: every wr_en/wr_addr equals rd_en/rd_addr exactly 2 cycles earlier; no stage-s+1 read occurs before the last stage-s write.
- Full datapath with N_LOG2=6, real RAM, Q1.15 twiddle ROM and butterfly; input x[0]=0x1000, all others 0 → all 64 bins read 0x1000 real, 0 imaginary.
- start held high through a whole transform → exactly one transform and one done pulse; a second transform begins only on the cycle after done.
- rst asserted at cycle 10 of an N_LOG2=3 run → next cycle busy=0, rd_en=0, wr_en=0, stage=0; no wr_en in the following 5 cycles.
- FFT_HOLD_EN, N_LOG2=3: hold=1 for cycles 2–4 → stage-0 issues at cycles 1,5,6,7; writes at 3,7,8,9; done at cycle 22.
